// File: rtl/tmr_pkg.sv
// Shared constants for the millisecond alarm: register map, CTRL bit positions, FSM states.
package tmr_pkg;
    localparam int REG_CTRL     = 0;
    localparam int REG_DEADLINE = 1;
    localparam int REG_INTERVAL = 2;
    localparam int REG_NOW      = 3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_PER   = 2;
    localparam int CTRL_PEND  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } tmr_state_t;
endpackage

// File: rtl/tmr_due.sv
// Wrap-safe deadline compare: due when enabled and the deadline is at most 2^31-1 ms behind now.
// Purely combinational, no backpressure.
module tmr_due (
    input  logic [31:0] i_now,
    input  logic [31:0] i_deadline,
    input  logic        i_en,
    output logic        o_due
);
    logic [31:0] w_diff;

    assign w_diff = i_now - i_deadline;
    assign o_due  = i_en & ~w_diff[31];
endmodule

// File: rtl/tmr_alarm.sv
// Millisecond alarm/IRQ generator on a single-cycle I/O bus; ack and PEND land one cycle after stb/due.
// Optional periodic reload (INTERVAL, PER) is built only when TMR_PERIODIC_EN is defined.
module tmr_alarm
    import tmr_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ms_cnt,
    input  logic              stb,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              ack,
    output logic              irq
);
    tmr_state_t  r_state;
    logic        r_en;
    logic        r_irqen;
    logic        r_pend;
    logic [31:0] r_deadline;
    logic [31:0] r_dout;
    logic        r_ack;

    logic        w_due;
    logic        w_event;
    logic        w_ctrl_wr;
    logic        w_dl_wr;
    logic        w_per;
    logic [31:0] w_interval;
    logic [31:0] w_rdata;

    tmr_due u_due (
        .i_now      (ms_cnt),
        .i_deadline (r_deadline),
        .i_en       (r_en),
        .o_due      (w_due)
    );

    assign w_event   = (r_state == ARMED) && w_due;
    assign w_ctrl_wr = stb && we && (addr == ADDR_W'(REG_CTRL));
    assign w_dl_wr   = stb && we && (addr == ADDR_W'(REG_DEADLINE));

`ifdef TMR_PERIODIC_EN
    logic        r_per;
    logic [31:0] r_interval;
    logic [31:0] w_reload;

    // A zero interval behaves as one so catch-up always makes progress.
    assign w_reload   = r_deadline + ((r_interval == '0) ? 32'd1 : r_interval);
    assign w_per      = r_per;
    assign w_interval = r_interval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per      <= 1'b0;
            r_interval <= '0;
        end else begin
            if (w_ctrl_wr)
                r_per <= din[CTRL_PER];
            if (stb && we && (addr == ADDR_W'(REG_INTERVAL)))
                r_interval <= din;
        end
    end
`else
    assign w_per      = 1'b0;
    assign w_interval = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (addr)
            ADDR_W'(REG_CTRL):     w_rdata = {28'd0, r_pend, w_per, r_irqen, r_en};
            ADDR_W'(REG_DEADLINE): w_rdata = r_deadline;
            ADDR_W'(REG_INTERVAL): w_rdata = w_interval;
            ADDR_W'(REG_NOW):      w_rdata = ms_cnt;
            default:               w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_irqen    <= 1'b0;
            r_pend     <= 1'b0;
            r_deadline <= '0;
            r_ack      <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_ack  <= stb;
            r_dout <= (stb && !we) ? w_rdata : '0;

            if (w_ctrl_wr) begin
                r_en    <= din[CTRL_EN];
                r_irqen <= din[CTRL_IRQEN];
            end

            // A due event in the same cycle as a W1C keeps PEND set.
            if (w_event)
                r_pend <= 1'b1;
            else if (w_ctrl_wr && din[CTRL_PEND])
                r_pend <= 1'b0;

            if (w_ctrl_wr && !din[CTRL_EN])
                r_state <= IDLE;
            else if (w_event)
                r_state <= w_per ? ARMED : FIRED;
            else if (w_ctrl_wr)
                r_state <= ARMED;

            if (w_dl_wr)
                r_deadline <= din;
`ifdef TMR_PERIODIC_EN
            else if (w_event && w_per)
                r_deadline <= w_reload;
`endif
        end
    end

    assign dout = r_dout;
    assign ack  = r_ack;
    assign irq  = r_pend & r_irqen;
endmodule

// File: tb/tb_tmr_alarm.sv
// Directed bench for tmr_alarm: bus/reset, one-shot, wrap, periodic or one-shot-only build, W1C race, mid-op reset.
module tb_tmr_alarm;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ms_cnt;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] v;
    logic [31:0] wrap_ms [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    tmr_alarm #(.ADDR_W(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .ms_cnt (ms_cnt),
        .stb    (stb),
        .we     (we),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .ack    (ack),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        stb = 1'b0; we = 1'b0;
        chk("wr_ack", 32'(ack), 32'd1);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        tick();
        stb = 1'b0;
        chk("rd_ack", 32'(ack), 32'd1);
        d = dout;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; din = '0;
        ms_cnt = 32'h1234_5678;
        tick(); tick();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dout", dout, 32'd0);
        rst = 1'b0;
        bus_rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
        bus_rd(2'd1, v); chk("rst_deadline", v, 32'd0);
        bus_rd(2'd2, v); chk("rst_interval", v, 32'd0);
        bus_rd(2'd3, v); chk("rst_now", v, 32'h1234_5678);
        tick();
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("dout_idle", dout, 32'd0);

        // one-shot at 100
        bus_wr(2'd1, 32'd100);
        ms_cnt = 32'd95;
        bus_wr(2'd0, 32'h3);
        for (int m = 95; m < 100; m++) begin
            ms_cnt = 32'(m);
            tick();
            chk("os_pre", 32'(irq), 32'd0);
        end
        ms_cnt = 32'd100; tick(); chk("os_rise", 32'(irq), 32'd1);
        ms_cnt = 32'd101; tick(); tick(); chk("os_hold", 32'(irq), 32'd1);
        bus_rd(2'd0, v); chk("os_ctrl", v, 32'hB);
        bus_wr(2'd0, 32'h8); chk("os_clr_irq", 32'(irq), 32'd0);
        ms_cnt = 32'd102; tick();
        bus_rd(2'd0, v); chk("os_ctrl_clr", v, 32'h0);

        // wrap-around compare
        bus_wr(2'd1, 32'd2);
        ms_cnt = 32'hFFFF_FFFD;
        bus_wr(2'd0, 32'h3);
        for (int i = 0; i < 4; i++) begin
            ms_cnt = wrap_ms[i];
            tick();
            chk("wrap_pre", 32'(irq), 32'd0);
        end
        ms_cnt = 32'd2; tick(); chk("wrap_rise", 32'(irq), 32'd1);
        bus_wr(2'd0, 32'h8);

`ifdef TMR_PERIODIC_EN
        bus_wr(2'd1, 32'd10);
        bus_wr(2'd2, 32'd5);
        ms_cnt = 32'd8;
        bus_wr(2'd0, 32'h7);
        bus_rd(2'd0, v); chk("per_ctrl", v, 32'h7);
        ms_cnt = 32'd9;  tick(); chk("per_pre", 32'(irq), 32'd0);
        ms_cnt = 32'd10; tick(); chk("per_10", 32'(irq), 32'd1);
        bus_rd(2'd1, v); chk("per_dl15", v, 32'd15);
        bus_wr(2'd0, 32'hF); chk("per_clr1", 32'(irq), 32'd0);
        ms_cnt = 32'd14; tick(); chk("per_14", 32'(irq), 32'd0);
        ms_cnt = 32'd15; tick(); chk("per_15", 32'(irq), 32'd1);
        bus_rd(2'd1, v); chk("per_dl20", v, 32'd20);
        bus_wr(2'd0, 32'hF); chk("per_clr2", 32'(irq), 32'd0);
        ms_cnt = 32'd20; tick(); chk("per_20", 32'(irq), 32'd1);
        bus_rd(2'd1, v); chk("per_dl25", v, 32'd25);
        // jump 20 -> 37: one interval added per cycle until deadline passes now
        ms_cnt = 32'd37; tick();
        stb = 1'b1; we = 1'b0; addr = 2'd1;
        tick(); chk("per_catch30", dout, 32'd30);
        tick(); chk("per_catch35", dout, 32'd35);
        tick(); chk("per_catch40", dout, 32'd40);
        stb = 1'b0;
        bus_rd(2'd1, v); chk("per_settled40", v, 32'd40);
        bus_wr(2'd0, 32'h8);
`else
        bus_wr(2'd2, 32'd5);
        bus_rd(2'd2, v); chk("np_interval", v, 32'd0);
        bus_wr(2'd1, 32'd200);
        ms_cnt = 32'd150;
        bus_wr(2'd0, 32'h7);
        bus_rd(2'd0, v); chk("np_ctrl", v, 32'h3);
        ms_cnt = 32'd200; tick(); chk("np_fire", 32'(irq), 32'd1);
        ms_cnt = 32'd205; tick(); tick();
        bus_rd(2'd1, v); chk("np_dl_kept", v, 32'd200);
        bus_rd(2'd0, v); chk("np_fired_ctrl", v, 32'hB);
        bus_wr(2'd0, 32'h8);
`endif

        // W1C in the same cycle as a due event: due wins
        bus_wr(2'd1, 32'd300);
        ms_cnt = 32'd300;
        bus_wr(2'd0, 32'h3);
        bus_wr(2'd0, 32'hB);
        chk("sim_irq", 32'(irq), 32'd1);
        bus_rd(2'd0, v); chk("sim_ctrl", v, 32'hB);
        bus_wr(2'd0, 32'hA);
        chk("sim_clr_irq", 32'(irq), 32'd0);
        bus_rd(2'd0, v); chk("sim_clr_ctrl", v, 32'h2);

        // mid-operation reset while ARMED with PEND set
        bus_wr(2'd0, 32'h3);
        bus_wr(2'd1, 32'd1000);
        bus_wr(2'd0, 32'h3);
        chk("mr_pre_irq", 32'(irq), 32'd1);
        rst = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0;
        tick();
        chk("mr_irq", 32'(irq), 32'd0);
        chk("mr_ack", 32'(ack), 32'd0);
        chk("mr_dout", dout, 32'd0);
        stb = 1'b0; rst = 1'b0;
        bus_rd(2'd0, v); chk("mr_ctrl", v, 32'd0);
        bus_rd(2'd1, v); chk("mr_deadline", v, 32'd0);
        bus_rd(2'd2, v); chk("mr_interval", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
